// File: rtl/de1_bt656_pkg.sv
// Shared constants, state encoding and XY protection helper for the BT.656 decoder.
package de1_bt656_pkg;

    localparam logic [7:0] TRS_FF = 8'hFF;
    localparam logic [7:0] TRS_00 = 8'h00;

    localparam int unsigned F_BIT = 6;
    localparam int unsigned V_BIT = 5;
    localparam int unsigned H_BIT = 4;

    typedef enum logic [2:0] {
        SEARCH,
        DATA,
        FF1,
        Z1,
        Z2
    } state_t;

    function automatic logic [3:0] xy_prot(input logic f, input logic v, input logic h);
        return {v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    endfunction

endpackage

// File: rtl/de1_bt656_xy_check.sv
// Splits a BT.656 XY byte into F/V/H and validates its protection nibble.
module de1_bt656_xy_check
    import de1_bt656_pkg::*;
(
    input  logic [7:0] i_xy,
    output logic       o_f_c,
    output logic       o_v_c,
    output logic       o_h_c,
    output logic       o_code_ok_c
);

    assign o_f_c       = i_xy[F_BIT];
    assign o_v_c       = i_xy[V_BIT];
    assign o_h_c       = i_xy[H_BIT];
    // Detection only; a corrupted code is rejected, never repaired.
    assign o_code_ok_c = i_xy[7] && (i_xy[3:0] == xy_prot(o_f_c, o_v_c, o_h_c));

endmodule

// File: rtl/de1_bt656_decoder.sv
// BT.656 byte-stream decoder: finds EAV/SAV, tracks line/field/lock, emits Y/C pixels.
module de1_bt656_decoder
    import de1_bt656_pkg::*;
#(
    parameter int unsigned ACTIVE_WIDTH = 720,
    parameter int unsigned LOCK_LINES   = 4,
    parameter int unsigned ERR_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             td_valid,
    input  logic [7:0]       td_data,
    input  logic             err_clear,
    output logic             pixel_valid,
    output logic [7:0]       pixel_y,
    output logic [7:0]       pixel_c,
    output logic [10:0]      pixel_x,
    output logic [9:0]       line,
    output logic             field,
    output logic             sol,
    output logic             sof,
    output logic             in_vblank,
    output logic             locked,
    output logic [ERR_W-1:0] err_count
);

    localparam int unsigned X_W    = 11;
    localparam int unsigned LINE_W = 10;
    localparam int unsigned GOOD_W = $clog2(LOCK_LINES + 1);

    localparam logic [X_W-1:0]    X_FULL    = X_W'(ACTIVE_WIDTH);
    localparam logic [X_W-1:0]    X_MAX     = '1;
    localparam logic [LINE_W-1:0] LINE_MAX  = '1;
    localparam logic [GOOD_W-1:0] GOOD_FULL = GOOD_W'(LOCK_LINES);
    localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

    state_t              r_state;
    state_t              r_prior;
    logic                r_active;
    logic [1:0]          r_phase;
    logic [7:0]          r_chroma;
    logic [X_W-1:0]      r_xcnt;
    logic                r_sol_arm;
    logic                r_sof_arm;
    logic                r_seen;
    logic                r_prev_v;
    logic                r_prev_f;
    logic [GOOD_W-1:0]   r_good;

    logic                w_f;
    logic                w_v;
    logic                w_h;
    logic                w_code_ok;
    logic                w_len_ok;
    logic                w_err;
    logic [GOOD_W-1:0]   w_good_nxt;

    de1_bt656_xy_check u_xy_check (
        .i_xy        (td_data),
        .o_f_c       (w_f),
        .o_v_c       (w_v),
        .o_h_c       (w_h),
        .o_code_ok_c (w_code_ok)
    );

    assign w_len_ok   = (r_xcnt == X_FULL);
    assign w_good_nxt = (r_good == GOOD_FULL) ? r_good : r_good + GOOD_W'(1);
    // Broken preamble, bad protection, or an active line of the wrong length.
    assign w_err = td_valid &&
                   ((((r_state == FF1) || (r_state == Z1)) && (td_data != TRS_00)) ||
                    ((r_state == Z2) && (!w_code_ok || (w_h && r_active && !w_len_ok))));

    // Byte FSM, line/field tracking and pixel output.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= SEARCH;
            r_prior     <= SEARCH;
            r_active    <= 1'b0;
            r_phase     <= '0;
            r_chroma    <= '0;
            r_xcnt      <= '0;
            r_sol_arm   <= 1'b0;
            r_sof_arm   <= 1'b0;
            r_seen      <= 1'b0;
            r_prev_v    <= 1'b0;
            r_prev_f    <= 1'b0;
            r_good      <= '0;
            pixel_valid <= 1'b0;
            pixel_y     <= '0;
            pixel_c     <= '0;
            pixel_x     <= '0;
            line        <= '0;
            field       <= 1'b0;
            sol         <= 1'b0;
            sof         <= 1'b0;
            in_vblank   <= 1'b0;
            locked      <= 1'b0;
        end else begin
            pixel_valid <= 1'b0;
            sol         <= 1'b0;
            sof         <= 1'b0;
            if (td_valid) begin
                case (r_state)
                    SEARCH, DATA: begin
                        if (td_data == TRS_FF) begin
                            r_prior <= r_state;
                            r_state <= FF1;
                        end else if ((r_state == DATA) && r_active) begin
                            r_phase <= r_phase + 2'd1;
                            if (!r_phase[0]) begin
                                r_chroma <= td_data;
                            end else begin
                                pixel_valid <= 1'b1;
                                pixel_y     <= td_data;
                                pixel_c     <= r_chroma;
                                pixel_x     <= r_xcnt;
                                sol         <= r_sol_arm;
                                sof         <= r_sof_arm;
                                r_sol_arm   <= 1'b0;
                                r_sof_arm   <= 1'b0;
                                if (r_xcnt != X_MAX) begin
                                    r_xcnt <= r_xcnt + X_W'(1);
                                end
                            end
                        end
                    end
                    FF1: r_state <= (td_data == TRS_00) ? Z1 : r_prior;
                    Z1:  r_state <= (td_data == TRS_00) ? Z2 : r_prior;
                    Z2: begin
                        r_state <= DATA;
                        if (!w_code_ok) begin
                            r_active <= 1'b0;
                            locked   <= 1'b0;
                            r_good   <= '0;
                        end else begin
                            r_seen    <= 1'b1;
                            r_prev_v  <= w_v;
                            r_prev_f  <= w_f;
                            in_vblank <= w_v;
                            if (!w_h) begin
                                field    <= w_f;
                                r_xcnt   <= '0;
                                r_phase  <= '0;
                                r_active <= !w_v;
                                if (!w_v) begin
                                    r_sol_arm <= 1'b1;
                                    // First active line after blanking or a field flip.
                                    if (!r_seen || r_prev_v || (w_f != r_prev_f)) begin
                                        line      <= '0;
                                        r_sof_arm <= 1'b1;
                                    end
                                end
                            end else begin
                                r_active <= 1'b0;
                                if (r_active) begin
                                    if (line != LINE_MAX) begin
                                        line <= line + LINE_W'(1);
                                    end
                                    if (w_len_ok) begin
                                        r_good <= w_good_nxt;
                                        locked <= (w_good_nxt == GOOD_FULL);
                                    end else begin
                                        r_good <= '0;
                                        locked <= 1'b0;
                                    end
                                end
                            end
                        end
                    end
                    default: r_state <= SEARCH;
                endcase
            end
        end
    end

    // Saturating error counter; a clear coinciding with an error leaves one.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count <= '0;
        end else if (err_clear) begin
            err_count <= w_err ? ERR_W'(1) : '0;
        end else if (w_err && (err_count != ERR_MAX)) begin
            err_count <= err_count + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_de1_bt656_decoder.sv
// Directed bench for de1_bt656_decoder: per-line vector table plus corner-case sequences.
module tb_de1_bt656_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        td_valid;
    logic [7:0]  td_data;
    logic        err_clear;
    logic        pixel_valid;
    logic [7:0]  pixel_y;
    logic [7:0]  pixel_c;
    logic [10:0] pixel_x;
    logic [9:0]  line;
    logic        field;
    logic        sol;
    logic        sof;
    logic        in_vblank;
    logic        locked;
    logic [7:0]  err_count;

    de1_bt656_decoder dut (
        .clk         (clk),
        .reset       (reset),
        .td_valid    (td_valid),
        .td_data     (td_data),
        .err_clear   (err_clear),
        .pixel_valid (pixel_valid),
        .pixel_y     (pixel_y),
        .pixel_c     (pixel_c),
        .pixel_x     (pixel_x),
        .line        (line),
        .field       (field),
        .sol         (sol),
        .sof         (sof),
        .in_vblank   (in_vblank),
        .locked      (locked),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] sav;
        logic [7:0] eav;
        int         npix;
        int         ins_at;
        bit         gaps;
        int         e_pix;
        int         e_sol;
        int         e_sof;
        int         e_pline;
        int         e_line;
        int         e_err;
        bit         e_lock;
        bit         e_vb;
        bit         e_field;
    } row_t;

    row_t rows[11];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   mon_cnt, mon_x, mon_bad, mon_sol, mon_sof, mon_pline;

    function automatic logic [7:0] exp_y(input int x);
        return 8'h10 + 8'(x % 200);
    endfunction

    function automatic logic [7:0] exp_c(input int x);
        int k = x / 2;
        return (x % 2 == 0) ? 8'h20 + 8'(k % 64) : 8'h80 + 8'(k % 64);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        mon_cnt = 0; mon_x = 0; mon_bad = 0; mon_sol = 0; mon_sof = 0; mon_pline = -1;
    endtask

    // Observes outputs #1 after the edge; want_pv says whether a pixel is due now.
    task automatic sample(input bit want_pv);
        if (pixel_valid !== want_pv) mon_bad++;
        if (pixel_valid === 1'b1) begin
            if (pixel_x !== 11'(mon_x) || pixel_y !== exp_y(mon_x) || pixel_c !== exp_c(mon_x)) mon_bad++;
            if ((sol || sof) && mon_x != 0) mon_bad++;
            if (sol) mon_sol++;
            if (sof) mon_sof++;
            if (mon_cnt == 0) mon_pline = int'(line);
            mon_cnt++;
            mon_x++;
        end else if (sol || sof) begin
            mon_bad++;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit want_pv);
        td_valid = 1'b1;
        td_data  = b;
        @(posedge clk);
        #1;
        td_valid = 1'b0;
        sample(want_pv);
    endtask

    task automatic idle();
        td_valid = 1'b0;
        td_data  = 8'hFF;
        @(posedge clk);
        #1;
        sample(1'b0);
    endtask

    task automatic send_code(input logic [7:0] xy);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(xy, 1'b0);
    endtask

    task automatic send_group(input int k, input bit act, input bit gaps, input bit ins);
        send_byte(exp_c(2 * k), 1'b0);
        if (gaps) idle();
        if (ins) begin
            send_byte(8'hFF, 1'b0);
            send_byte(8'h00, 1'b0);
            send_byte(8'h12, 1'b0);
        end
        send_byte(exp_y(2 * k), act);
        if (gaps) idle();
        send_byte(exp_c(2 * k + 1), 1'b0);
        if (gaps) idle();
        send_byte(exp_y(2 * k + 1), act);
        if (gaps) idle();
    endtask

    task automatic run_row(input int i);
        row_t r = rows[i];
        clear_mon();
        send_code(r.sav);
        for (int k = 0; k < r.npix / 2; k++) send_group(k, r.e_pix > 0, r.gaps, k == r.ins_at);
        send_code(r.eav);
        check($sformatf("row%0d pixels", i), 64'(mon_cnt), 64'(r.e_pix));
        check($sformatf("row%0d sol", i), 64'(mon_sol), 64'(r.e_sol));
        check($sformatf("row%0d sof", i), 64'(mon_sof), 64'(r.e_sof));
        check($sformatf("row%0d pixel_stream", i), 64'(mon_bad), 64'd0);
        if (r.e_pix > 0) check($sformatf("row%0d line_during", i), 64'(mon_pline), 64'(r.e_pline));
        check($sformatf("row%0d line_after", i), 64'(line), 64'(r.e_line));
        check($sformatf("row%0d err_count", i), 64'(err_count), 64'(r.e_err));
        check($sformatf("row%0d locked", i), 64'(locked), 64'(r.e_lock));
        check($sformatf("row%0d in_vblank", i), 64'(in_vblank), 64'(r.e_vb));
        check($sformatf("row%0d field", i), 64'(field), 64'(r.e_field));
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({pixel_valid, pixel_y, pixel_c, pixel_x, line, field, sol, sof,
                    in_vblank, locked, err_count});
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        //           sav    eav    npix ins gap pix sol sof pln ln err lk vb f
        rows[0]  = '{8'hAB, 8'hB6, 720, -1, 0,   0, 0, 0, 0, 0, 0, 0, 1, 0};
        rows[1]  = '{8'h80, 8'h9D, 720, -1, 0, 720, 1, 1, 0, 1, 0, 0, 0, 0};
        rows[2]  = '{8'h81, 8'h9D, 720, -1, 0,   0, 0, 0, 0, 1, 1, 0, 0, 0};
        rows[3]  = '{8'h80, 8'h9D, 718, -1, 0, 718, 1, 0, 1, 2, 2, 0, 0, 0};
        rows[4]  = '{8'h80, 8'h9D, 720, -1, 0, 720, 1, 0, 2, 3, 2, 0, 0, 0};
        rows[5]  = '{8'h80, 8'h9D, 720, -1, 1, 720, 1, 0, 3, 4, 2, 0, 0, 0};
        rows[6]  = '{8'h80, 8'h9D, 720, -1, 0, 720, 1, 0, 4, 5, 2, 0, 0, 0};
        rows[7]  = '{8'h80, 8'h9D, 720, -1, 0, 720, 1, 0, 5, 6, 2, 1, 0, 0};
        rows[8]  = '{8'h80, 8'h9D, 720, 50, 0, 720, 1, 0, 6, 7, 3, 1, 0, 0};
        rows[9]  = '{8'hC7, 8'hDA, 720, -1, 0, 720, 1, 1, 0, 1, 3, 1, 0, 1};
        rows[10] = '{8'hC7, 8'hDA, 720, -1, 0, 720, 1, 1, 0, 1, 0, 0, 0, 1};

        reset = 1'b1; td_valid = 1'b0; td_data = 8'h00; err_clear = 1'b0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", all_outs(), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) run_row(i);

        // Error counter saturation and clear interaction.
        for (int i = 0; i < 260; i++) begin
            send_byte(8'hFF, 1'b0);
            send_byte(8'h12, 1'b0);
        end
        check("err saturated", 64'(err_count), 64'd255);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h12, 1'b0);
        check("err stays saturated", 64'(err_count), 64'd255);
        send_byte(8'hFF, 1'b0);
        err_clear = 1'b1;
        send_byte(8'h12, 1'b0);
        err_clear = 1'b0;
        check("err clear with error", 64'(err_count), 64'd1);
        err_clear = 1'b1;
        idle();
        err_clear = 1'b0;
        check("err clear alone", 64'(err_count), 64'd0);

        // Reset in the middle of an active line.
        clear_mon();
        send_code(8'h80);
        for (int k = 0; k < 151; k++) send_group(k, 1'b1, 1'b0, 1'b0);
        check("partial line pixels", 64'(mon_cnt), 64'd302);
        check("partial line stream", 64'(mon_bad), 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid-line reset outputs", all_outs(), 64'd0);
        reset = 1'b0;
        clear_mon();
        for (int i = 0; i < 40; i++) send_byte(8'h20 + 8'(i), 1'b0);
        check("data before SAV ignored", 64'(mon_cnt + mon_bad), 64'd0);
        run_row(10);

        // Sweep every XY value through a code preamble.
        begin
            int  exp_err = 0;
            bit  f, v, h, ok;
            logic [7:0] xy;
            for (int n = 0; n < 256; n++) begin
                xy = 8'(n);
                f = xy[6]; v = xy[5]; h = xy[4];
                ok = xy[7] && (xy[3] == (v ^ h)) && (xy[2] == (f ^ h)) &&
                     (xy[1] == (f ^ v)) && (xy[0] == (f ^ v ^ h));
                send_code(xy);
                if (!ok) exp_err++;
                check($sformatf("xy %02h err_count", n), 64'(err_count), 64'(exp_err));
                if (ok) check($sformatf("xy %02h in_vblank", n), 64'(in_vblank), 64'(v));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
